ahb_lite_stream_loader: RTL and testbench
=========================================

Name: ahb_lite_stream_loader

Overview:
AHB-Lite single-master write engine sitting directly upstream of the on-chip AHB-Lite memory. It accepts a byte stream over a valid/ready interface, for example from a UART receiver, and packs the bytes little-endian into 32-bit words. Each word is written to consecutive word addresses from BASE_ADDR using non-pipelined SINGLE word transfers. It is used to load program images into memory while the core is held off the bus.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; bits [1:0] must be 0.
CNT_W, 16, width of the word counter and of load_words.

Ports:
HCLK  in  1  bus clock, single clock domain.
HRESETn  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
load_words  in  CNT_W  number of words to write; sampled with start.
rx_data  in  8  stream byte.
rx_valid  in  1  stream byte valid.
rx_ready  out  1  loader accepts a byte; a byte transfers when rx_valid & rx_ready at a HCLK edge.
busy  out  1  high from the cycle after start is accepted until DONE is left.
done  out  1  one-cycle pulse when the load finishes or aborts.
err  out  1  sticky flag for an ERROR response seen during the load; cleared on the next accepted start.
HADDR  out  32  AHB address.
HTRANS  out  2  AHB transfer type; only IDLE (00) or NONSEQ (10) is driven.
HWRITE  out  1  AHB write.
HSIZE  out  3  AHB size; always 3'b010 when NONSEQ.
HBURST  out  3  constant 3'b000 (SINGLE).
HPROT  out  4  constant 4'b0011.
HWDATA  out  32  AHB write data, valid in the data phase.
HREADY  in  1  AHB ready from slave/mux.
HRESP  in  1  AHB response; 1 = ERROR.

Behaviour:
- All outputs are registered. Reset (asynchronous, HRESETn low) forces:
  - state IDLE, rx_ready=0, busy=0, done=0, err=0;
  - HTRANS=00, HWRITE=0, HADDR=BASE_ADDR, HSIZE=3'b010, HWDATA=0;
  - word counter=0, byte index=0, pack register=0.
- Reset mid-load abandons the load immediately: the partial word is discarded, no done pulse is issued, and the bus goes IDLE.
- States: IDLE, COLLECT, ADDR, DATA, FIN.
- IDLE:
  - start=1 and load_words≠0 -> COLLECT; latch load_words; clear err and counter; byte index=0.
  - start=1 and load_words=0 -> FIN; no bus transfer occurs.
- COLLECT:
  - rx_ready=1.
  - Each accepted byte k (0..3) is stored in pack[8k+7:8k], so the first byte lands in the LSB.
  - On acceptance of the 4th byte -> ADDR. rx_ready drops in the same edge.
- ADDR:
  - Drive HTRANS=NONSEQ, HWRITE=1, HSIZE=010, HADDR=BASE_ADDR+4*counter.
  - NONSEQ appears on the bus the cycle after the 4th-byte handshake.
  - Hold all of these until a cycle with HREADY=1, then -> DATA.
- DATA:
  - HTRANS=IDLE, HWRITE=0, HWDATA=pack, held until HREADY=1.
  - On completion, if HRESP=1: set err, then -> FIN, aborting the remaining words.
  - Otherwise increment counter; counter==latched load_words -> FIN, else -> COLLECT.
- FIN: done=1 for exactly one cycle, then -> IDLE.
- busy=1 in COLLECT, ADDR, DATA and FIN.
- Two-cycle ERROR response: the first cycle (HRESP=1, HREADY=0) is treated as a wait state; err is captured on the HREADY=1 cycle.
- start while not IDLE is ignored.
- rx_valid while rx_ready=0 is not consumed; the stream source must hold the byte.
- Address arithmetic is 32-bit modulo 2^32. Words beyond the memory size alias in the target; the loader does not check this.
- Best-case throughput: one word per 4 stream cycles plus 2 bus cycles.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE/NONSEQ;
  - HSIZE_WORD;
  - HBURST_SINGLE;
  - HPROT_DATA_PRIV (4'b0011);
  - the loader state encoding.
- One sub-module: ahb_byte_packer. It takes the byte stream in and produces a 32-bit word plus a word_valid/word_ready handshake, and holds the byte index and pack register.

Test Plan:
- Load 2 words, BASE_ADDR=0, bytes 11 22 33 44 55 66 77 88, zero-wait memory:
  - writes 32'h44332211 @0x0 and 32'h88776655 @0x4;
  - done pulses once; err=0.
- HREADY held low 3 cycles in the ADDR phase and 2 in the DATA phase:
  - HADDR, HTRANS and HWDATA are stable throughout each stall;
  - memory contents are identical to the zero-wait case.
- rx_valid gapped (bytes every 5th cycle) with load_words=1:
  - NONSEQ appears exactly 1 cycle after the 4th handshake;
  - rx_ready is low during ADDR and DATA.
- load_words=0: done pulses the cycle after start; HTRANS stays 00 throughout.
- ERROR response on word 1 of 3:
  - err=1 and done pulses;
  - no third transfer; word 0 is written and word 1 is not.
- Reset asserted mid-COLLECT after 2 bytes, then a new start with load_words=1:
  - no write from the stale bytes;
  - the first word written equals the first 4 new bytes.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and the stream loader state encoding.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE     = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
    localparam logic [2:0] HSIZE_WORD      = 3'b010;
    localparam logic [2:0] HBURST_SINGLE   = 3'b000;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCollect = 3'd1,
        StAddr    = 3'd2,
        StData    = 3'd3,
        StFin     = 3'd4
    } loader_state_e;

    // Byte address of word number idx, wrapping modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/ahb_byte_packer.sv
// Packs an 8-bit stream little-endian into 32-bit words with a word handshake.
module ahb_byte_packer
    import ahb_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        enable,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        last_byte,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready
);

    logic [1:0]  idx;
    logic [31:0] pack;
    logic        take;

    // enable is the loader's registered rx_ready, so a transfer is exactly take.
    assign take      = in_valid & enable;
    assign last_byte = take & (idx == 2'd3);
    assign word      = pack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= 2'd0;
            pack       <= 32'h0;
            word_valid <= 1'b0;
        end else if (clear) begin
            idx        <= 2'd0;
            pack       <= 32'h0;
            word_valid <= 1'b0;
        end else begin
            if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (take) begin
                pack[{idx, 3'b000} +: 8] <= in_data;
                idx                      <= idx + 2'd1;
                if (idx == 2'd3) begin
                    word_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_lite_stream_loader.sv
// AHB-Lite single-master loader: packs a byte stream into words and writes them
// to consecutive word addresses with non-pipelined SINGLE transfers.
module ahb_lite_stream_loader
    import ahb_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [CNT_W-1:0] load_words,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic             HWRITE,
    output logic [2:0]       HSIZE,
    output logic [2:0]       HBURST,
    output logic [3:0]       HPROT,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic             HRESP
);

    loader_state_e    state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] words_total;

    logic             pk_clear;
    logic             last_byte;
    logic [31:0]      word;
    logic             word_valid;
    logic             word_ready;

    assign HSIZE  = HSIZE_WORD;
    assign HBURST = HBURST_SINGLE;
    assign HPROT  = HPROT_DATA_PRIV;

    assign cnt_inc    = cnt + 1'b1;
    assign pk_clear   = (state == StIdle) && start;
    assign word_ready = (state == StData) && HREADY;

    ahb_byte_packer u_packer (
        .clk        (HCLK),
        .rst_n      (HRESETn),
        .clear      (pk_clear),
        .enable     (rx_ready),
        .in_data    (rx_data),
        .in_valid   (rx_valid),
        .last_byte  (last_byte),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= StIdle;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
            HADDR       <= BASE_ADDR;
            HWDATA      <= 32'h0;
            cnt         <= '0;
            words_total <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        err         <= 1'b0;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        words_total <= load_words;
                        if (load_words != '0) begin
                            state    <= StCollect;
                            rx_ready <= 1'b1;
                        end else begin
                            state <= StFin;
                            done  <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    // rx_ready drops on the same edge that takes the 4th byte.
                    if (last_byte) begin
                        state    <= StAddr;
                        rx_ready <= 1'b0;
                        HTRANS   <= HTRANS_NONSEQ;
                        HWRITE   <= 1'b1;
                        HADDR    <= word_addr(BASE_ADDR, 32'(cnt));
                    end
                end
                StAddr: begin
                    if (HREADY && word_valid) begin
                        state  <= StData;
                        HTRANS <= HTRANS_IDLE;
                        HWRITE <= 1'b0;
                        HWDATA <= word;
                    end
                end
                StData: begin
                    // An ERROR first shows with HREADY low; it is only acted on
                    // in the final HREADY-high cycle.
                    if (HREADY) begin
                        if (HRESP) begin
                            err   <= 1'b1;
                            state <= StFin;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == words_total) begin
                                state <= StFin;
                                done  <= 1'b1;
                            end else begin
                                state    <= StCollect;
                                rx_ready <= 1'b1;
                            end
                        end
                    end
                end
                StFin: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_stream_loader.sv
// Directed and randomized bench for ahb_lite_stream_loader with a behavioural
// AHB-Lite slave and a stream-to-word reference model.
module tb_ahb_lite_stream_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] load_words = 16'h0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready, busy, done, err;
    logic [31:0] HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;

    int checks = 0;
    int errors = 0;

    ahb_lite_stream_loader #(
        .BASE_ADDR (BASE),
        .CNT_W     (16)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .start      (start),
        .load_words (load_words),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HBURST     (HBURST),
        .HPROT      (HPROT),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave behaviour knobs, written only by the stimulus block.
    int aw = 0, dw = 0, err_word = -1, gap = 1;
    int load_id = 0, clr_id = 0;
    logic [7:0] stream[$];

    // Stream source: owns rx_valid/rx_data and the byte pointer.
    int  ptr = 0, pcyc = 0, src_seen = 0;
    bit  hs_pend = 0;
    always @(posedge HCLK) begin
        #1;
        pcyc++;
        if (src_seen != load_id) begin
            src_seen = load_id;
            ptr      = 0;
            rx_valid = 1'b0;
        end else if (hs_pend) begin
            ptr++;
            rx_valid = 1'b0;
        end
        if (!rx_valid && ptr < stream.size() && (gap <= 1 || pcyc % gap == 0)) begin
            rx_valid = 1'b1;
            rx_data  = stream[ptr];
        end
    end

    // Monitor and AHB slave, sampling on the falling edge.
    int  ncyc = 0, last_hs = -10, mon_seen = 0;
    int  done_cnt = 0, done_bad = 0, nonseq_cnt = 0, lag_bad = 0, rx_bad = 0, stall_bad = 0;
    int  xfer_idx = 0, scnt = 0;
    bit  dphase = 0, aseen = 0, err_second = 0, prev_done = 0;
    logic [31:0] cur_addr = 0, hold_addr = 0, hold_data = 0;
    logic [63:0] writes[$];
    always @(negedge HCLK) begin
        ncyc++;
        if (mon_seen != clr_id) begin
            mon_seen = clr_id;
            done_cnt = 0; done_bad = 0; nonseq_cnt = 0; lag_bad = 0; rx_bad = 0;
            stall_bad = 0; xfer_idx = 0; dphase = 0; aseen = 0; writes = {};
        end
        hs_pend = rx_valid & rx_ready;
        if (hs_pend) last_hs = ncyc;
        if (done) begin
            done_cnt++;
            if (prev_done) done_bad++;
        end
        prev_done = done;
        if (dphase) begin
            if (rx_ready) rx_bad++;
            if (HTRANS !== 2'b00) stall_bad++;
            if (scnt == 0) hold_data = HWDATA;
            else if (HWDATA !== hold_data) stall_bad++;
            if (xfer_idx == err_word && scnt >= dw) begin
                if (!err_second) begin
                    HREADY = 1'b0; HRESP = 1'b1; err_second = 1; scnt++;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b1; dphase = 0; xfer_idx++;
                end
            end else if (scnt < dw) begin
                HREADY = 1'b0; HRESP = 1'b0; scnt++;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
                writes.push_back({cur_addr, HWDATA});
                dphase = 0; xfer_idx++;
            end
        end else if (HTRANS == 2'b10) begin
            if (rx_ready) rx_bad++;
            if (!aseen) begin
                aseen = 1; nonseq_cnt++; scnt = 0; hold_addr = HADDR;
                if (last_hs != ncyc - 1) lag_bad++;
            end else if (HADDR !== hold_addr || HWRITE !== 1'b1) begin
                stall_bad++;
            end
            if (scnt < aw) begin
                HREADY = 1'b0; HRESP = 1'b0; scnt++;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; cur_addr = HADDR;
                dphase = 1; aseen = 0; scnt = 0; err_second = 0;
            end
        end else begin
            if (aseen) stall_bad++;
            aseen = 0;
            HREADY = 1'b1; HRESP = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(posedge HCLK); #1;
        start = 1'b1; load_words = n;
        @(posedge HCLK); #1;
        start = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rx_ready"}, rx_ready, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " HTRANS"}, HTRANS, 0);
        chk({tag, " HWRITE"}, HWRITE, 0);
        chk({tag, " HADDR"}, HADDR, BASE);
        chk({tag, " HSIZE"}, HSIZE, 3'b010);
    endtask

    // Reference model: word i = bytes 4i..4i+3 little-endian at BASE+4i, stopping
    // before the erroring word, which still costs one address phase.
    task automatic run_load(input string name, input int nw, input int g, input int a,
                            input int d, input int ew, input bit fixed);
        logic [7:0]  b[$];
        logic [31:0] exp_data;
        int          exp_w, exp_x;
        bit          exp_err, seen;
        for (int i = 0; i < 4 * nw; i++) b.push_back(fixed ? 8'(8'h11 * (i + 1)) : 8'($urandom));
        gap = g; aw = a; dw = d; err_word = ew;
        stream = b;
        load_id++; clr_id++;
        @(negedge HCLK);
        pulse_start(16'(nw));
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge HCLK);
            if (done) seen = 1;
        end
        exp_err = (ew >= 0 && ew < nw);
        exp_w   = exp_err ? ew : nw;
        exp_x   = exp_err ? ew + 1 : nw;
        chk({name, " done seen"}, seen, 1);
        chk({name, " err at done"}, err, exp_err);
        chk({name, " busy at done"}, busy, 1);
        repeat (3) @(negedge HCLK);
        chk({name, " done pulses"}, done_cnt, 1);
        chk({name, " done width"}, done_bad, 0);
        chk({name, " busy after"}, busy, 0);
        chk({name, " err sticky"}, err, exp_err);
        chk({name, " transfers"}, nonseq_cnt, exp_x);
        chk({name, " writes"}, writes.size(), exp_w);
        chk({name, " stall stable"}, stall_bad, 0);
        chk({name, " rx_ready in bus"}, rx_bad, 0);
        chk({name, " nonseq lag"}, lag_bad, 0);
        for (int i = 0; i < exp_w && i < writes.size(); i++) begin
            exp_data = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
            chk({name, " write"}, writes[i], {BASE + 32'(4 * i), exp_data});
        end
    endtask

    logic [63:0] ref_writes[$];

    initial begin
        #12;
        chk_reset_values("reset");
        chk("reset err", err, 0);
        chk("reset HWDATA", HWDATA, 0);
        chk("HBURST", HBURST, 3'b000);
        chk("HPROT", HPROT, 4'b0011);
        repeat (2) @(negedge HCLK);
        #2 HRESETn = 1'b1;

        run_load("basic", 2, 1, 0, 0, -1, 1);
        if (writes.size() == 2) begin
            chk("basic w0", writes[0], {32'h0, 32'h44332211});
            chk("basic w1", writes[1], {32'h4, 32'h88776655});
        end else begin
            chk("basic count", writes.size(), 2);
        end
        ref_writes = writes;

        run_load("stall", 2, 1, 3, 2, -1, 1);
        chk("stall count", writes.size(), ref_writes.size());
        for (int i = 0; i < writes.size() && i < ref_writes.size(); i++)
            chk("stall same", writes[i], ref_writes[i]);

        run_load("gap", 1, 5, 0, 0, -1, 0);

        // Zero-length load.
        clr_id++;
        @(negedge HCLK);
        pulse_start(16'd0);
        @(negedge HCLK);
        chk("zero done", done, 1);
        chk("zero busy", busy, 1);
        @(negedge HCLK);
        chk("zero done drop", done, 0);
        repeat (3) @(negedge HCLK);
        chk("zero transfers", nonseq_cnt, 0);
        chk("zero pulses", done_cnt, 1);

        run_load("error", 3, 1, 0, 0, 1, 0);
        run_load("error stall", 2, 2, 1, 1, 0, 0);

        // Reset in the middle of collecting a word.
        gap = 1; aw = 0; dw = 0; err_word = -1;
        stream = {8'hde, 8'had};
        load_id++; clr_id++;
        @(negedge HCLK);
        pulse_start(16'd1);
        for (int i = 0; i < 200 && ptr < 2; i++) @(negedge HCLK);
        chk("rst bytes taken", ptr, 2);
        repeat (2) @(negedge HCLK);
        #2 HRESETn = 1'b0;
        #1;
        chk_reset_values("midreset");
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        repeat (3) @(negedge HCLK);
        chk("rst no stale write", writes.size(), 0);
        run_load("after reset", 1, 1, 0, 0, -1, 0);

        for (int k = 0; k < 3; k++)
            run_load("rand", int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, 0);
        run_load("rand err", 4, 1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
